// File: rtl/cpu_pio_led_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pio_led_pkg
//   Shared definitions for the LED output PIO: register word offsets, the
//   STATUS bit layout, and the write-strobe decode used by the top level.
// ---------------------------------------------------------------------------
package cpu_pio_led_pkg;

  // Register word offsets on the slave port.
  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  // STATUS register layout.
  localparam int STATUS_PHASE_BIT = 0;

  // One-hot view of "which register is being written this cycle".
  typedef struct packed {
    logic data;
    logic blink_en;
    logic period;
    logic outset;
    logic outclear;
  } wr_dec_t;

  // Decode a bus write into per-register strobes. STATUS and offsets 6/7
  // have no strobe, so writes to them fall through and are ignored.
  function automatic wr_dec_t decode_write(input logic       wr_en,
                                           input logic [2:0] addr);
    wr_dec_t d;
    d          = '0;
    d.data     = wr_en && (addr == ADDR_DATA);
    d.blink_en = wr_en && (addr == ADDR_BLINK_EN);
    d.period   = wr_en && (addr == ADDR_PERIOD);
    d.outset   = wr_en && (addr == ADDR_OUTSET);
    d.outclear = wr_en && (addr == ADDR_OUTCLEAR);
    return d;
  endfunction

endpackage

// File: rtl/cpu_pio_led_blink_timer.sv
// ---------------------------------------------------------------------------
// cpu_pio_led_blink_timer
//   Half-period counter and blink phase for the LED PIO. The phase toggles
//   once every `period` cycles; a period of zero freezes counter and phase.
//
// Ports
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   period     current PERIOD register value (half-period in cycles)
//   period_wr  PERIOD is being written this cycle; restarts the timer
//   phase      current blink phase
// ---------------------------------------------------------------------------
module cpu_pio_led_blink_timer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] period,
  input  logic        period_wr,
  output logic        phase
);

  logic [31:0] cnt;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, whatever the block order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (period_wr) begin
      // A new period restarts from a clean state. This also covers the case
      // where cnt is already beyond the new terminal count, which would
      // otherwise run the full 32-bit range before matching.
      cnt   <= '0;
      phase <= 1'b0;
    end else if (period != 32'd0) begin
      if (cnt == period - 32'd1) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/cpu_pio_led_0.sv
// ---------------------------------------------------------------------------
// cpu_pio_led_0
//   Avalon-MM output PIO driving the board LEDs. Provides a DATA register,
//   atomic set/clear aliases, and a per-bit hardware blink engine.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     word offset of the slave register
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    registered read data (1-cycle latency, no read strobe)
//   out_port    registered LED drive
// ---------------------------------------------------------------------------
module cpu_pio_led_0
  import cpu_pio_led_pkg::*;
#(
  parameter int               WIDTH          = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
  parameter logic [31:0]      DEFAULT_PERIOD = 32'd25000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] blink_en_q;
  logic [31:0]      period_q;
  logic             phase;
  logic [31:0]      rd_mux;
  wr_dec_t          wr;

  assign wr = decode_write(chipselect && !write_n, address);

  // -------------------------------------------------------------------------
  // Register file
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= RESET_VALUE;
      blink_en_q <= '0;
      period_q   <= DEFAULT_PERIOD;
    end else begin
      // Only one strobe can be active per cycle, so the priority order of
      // the DATA / OUTSET / OUTCLEAR branches never matters.
      if (wr.data)
        data_q <= writedata[WIDTH-1:0];
      else if (wr.outset)
        data_q <= data_q | writedata[WIDTH-1:0];
      else if (wr.outclear)
        data_q <= data_q & ~writedata[WIDTH-1:0];

      if (wr.blink_en)
        blink_en_q <= writedata[WIDTH-1:0];

      if (wr.period)
        period_q <= writedata;
    end
  end

  // -------------------------------------------------------------------------
  // Blink engine
  // -------------------------------------------------------------------------
  cpu_pio_led_blink_timer u_blink_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .period    (period_q),
    .period_wr (wr.period),
    .phase     (phase)
  );

  // -------------------------------------------------------------------------
  // Read mux: always decoded from address, regardless of chipselect, so it
  // behaves like the input PIOs on the same fabric.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaulting rd_mux before the case keeps every path assigned,
    // so no latch is inferred for unlisted offsets.
    rd_mux = '0;
    case (address)
      ADDR_DATA:     rd_mux[WIDTH-1:0]        = data_q;
      ADDR_BLINK_EN: rd_mux[WIDTH-1:0]        = blink_en_q;
      ADDR_PERIOD:   rd_mux                   = period_q;
      ADDR_STATUS:   rd_mux[STATUS_PHASE_BIT] = phase;
      default:       rd_mux                   = '0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      out_port <= RESET_VALUE;
    end else begin
      readdata <= rd_mux;
      // A blinking bit shows DATA in phase 0 and ~DATA in phase 1.
      out_port <= data_q ^ (blink_en_q & {WIDTH{phase}});
    end
  end

endmodule

// File: tb/tb_cpu_pio_led_0.sv
// ---------------------------------------------------------------------------
// tb_cpu_pio_led_0
//   Directed self-checking bench for cpu_pio_led_0 (WIDTH=8,
//   RESET_VALUE=8'hA5, DEFAULT_PERIOD=25000000). Inputs change and outputs
//   are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_cpu_pio_led_0;
  import cpu_pio_led_pkg::*;

  localparam int          WIDTH  = 8;
  localparam logic [7:0]  RST_V  = 8'hA5;
  localparam logic [31:0] DEF_P  = 32'd25000000;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int checks   = 0;
  int failures = 0;

  cpu_pio_led_0 #(
    .WIDTH          (WIDTH),
    .RESET_VALUE    (RST_V),
    .DEFAULT_PERIOD (DEF_P)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the write lands on the next rising edge and
  // the task returns at the following falling edge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // Called at a falling edge; returns readdata one edge later.
  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  logic [31:0] r;
  logic [7:0]  exp_out;
  logic [7:0]  frozen;
  int          diffs;

  initial begin
    reset_n    = 1'b0;
    address    = ADDR_DATA;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;

    // ---- Reset state --------------------------------------------------
    #12;
    check("rst_out_port", {24'd0, out_port}, {24'd0, RST_V});
    check("rst_readdata", readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_out_port", {24'd0, out_port}, {24'd0, RST_V});
    rd(ADDR_PERIOD, r);
    check("rd_default_period", r, DEF_P);
    rd(ADDR_BLINK_EN, r);
    check("rd_reset_blink_en", r, 32'd0);

    // ---- DATA / OUTSET / OUTCLEAR ------------------------------------
    wr(ADDR_DATA, 32'hFFFF_FF0F);      // upper bits are not stored
    check("rd_same_cycle_old", readdata, {24'd0, RST_V});
    rd(ADDR_DATA, r);
    check("rd_data_masked", r, 32'h0000_000F);
    wr(ADDR_OUTSET, 32'h0000_0030);
    wr(ADDR_OUTCLEAR, 32'h0000_0001);
    rd(ADDR_DATA, r);
    check("rd_data_set_clr", r, 32'h0000_003E);
    check("out_set_clr", {24'd0, out_port}, 32'h0000_003E);
    rd(ADDR_OUTSET, r);
    check("rd_outset_zero", r, 32'd0);
    rd(ADDR_OUTCLEAR, r);
    check("rd_outclear_zero", r, 32'd0);
    wr(ADDR_STATUS, 32'hFFFF_FFFF);    // read-only: ignored
    wr(3'd6, 32'hFFFF_FFFF);           // unmapped: ignored
    wr(3'd7, 32'hFFFF_FFFF);
    rd(ADDR_DATA, r);
    check("ignored_writes_data", r, 32'h0000_003E);
    rd(3'd6, r);
    check("rd_off6_zero", r, 32'd0);
    check("ignored_writes_out", {24'd0, out_port}, 32'h0000_003E);

    // ---- Blink with PERIOD=4 -----------------------------------------
    // PERIOD write at edge W: phase=0, cnt=0; phase toggles at W+4, W+8...
    // Phase after edge W+j is (j/4)%2; out_port and STATUS readdata after
    // edge W+k both reflect phase after W+k-1.
    wr(ADDR_PERIOD, 32'd4);            // edge W
    wr(ADDR_BLINK_EN, 32'h81);         // edge W+1
    wr(ADDR_DATA, 32'h00);             // edge W+2
    address = ADDR_STATUS;
    for (int k = 3; k <= 18; k++) begin
      @(negedge clk);                  // now just after edge W+k
      exp_out = (((k - 1) / 4) % 2 != 0) ? 8'h81 : 8'h00;
      check($sformatf("blink4_out_k%0d", k), {24'd0, out_port},
            {24'd0, exp_out});
      check($sformatf("blink4_status_k%0d", k), readdata,
            {31'd0, exp_out[0]});
    end

    // ---- PERIOD rewrite mid-blink (phase=1, cnt=2) --------------------
    wr(ADDR_PERIOD, 32'd4);            // edge W2: phase=0, cnt=0
    idle(6);                           // state after W2+6: phase=1, cnt=2
    wr(ADDR_PERIOD, 32'd3);            // edge E=W2+7: phase=0, cnt=0
    check("rewrite_out_E", {24'd0, out_port}, 32'h0000_0081);
    address = ADDR_STATUS;
    // Phase after E+j is (j/3)%2.
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      exp_out = (((k - 1) / 3) % 2 != 0) ? 8'h81 : 8'h00;
      check($sformatf("rewrite3_out_k%0d", k), {24'd0, out_port},
            {24'd0, exp_out});
      check($sformatf("rewrite3_status_k%0d", k), readdata,
            {31'd0, exp_out[0]});
    end

    // ---- PERIOD=0 freezes blinking -----------------------------------
    wr(ADDR_PERIOD, 32'd0);
    @(negedge clk);
    frozen = out_port;
    check("freeze_value", {24'd0, frozen}, 32'h0000_0000);
    diffs = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_port !== frozen) diffs++;
    end
    check("freeze_100_cycles", diffs, 32'd0);
    rd(ADDR_STATUS, r);
    check("freeze_status", r, 32'd0);

    // ---- PERIOD=1: toggle every cycle --------------------------------
    wr(ADDR_PERIOD, 32'd1);            // edge P: phase=0; phase after P+j = j%2
    wr(ADDR_BLINK_EN, 32'hFF);         // edge P+1
    wr(ADDR_DATA, 32'h55);             // edge P+2
    address = ADDR_DATA;
    for (int k = 3; k <= 10; k++) begin
      @(negedge clk);
      exp_out = (((k - 1) % 2) != 0) ? 8'hAA : 8'h55;
      check($sformatf("period1_out_k%0d", k), {24'd0, out_port},
            {24'd0, exp_out});
    end
    check("period1_rd_data", readdata, 32'h0000_0055);

    // ---- Asynchronous reset mid-blink --------------------------------
    #2;
    reset_n = 1'b0;
    #1;                                // no clock edge in between
    check("async_rst_out", {24'd0, out_port}, {24'd0, RST_V});
    check("async_rst_readdata", readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    diffs = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_port !== RST_V) diffs++;
    end
    check("post_rst_no_blink", diffs, 32'd0);
    rd(ADDR_BLINK_EN, r);
    check("post_rst_blink_en", r, 32'd0);
    rd(ADDR_PERIOD, r);
    check("post_rst_period", r, DEF_P);
    rd(ADDR_DATA, r);
    check("post_rst_data", r, {24'd0, RST_V});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_pio_led_0.md
# cpu_pio_led_0

Avalon-MM write/read output parallel port that drives board LEDs from the Nios II CPU. It is the output-direction counterpart to the key input PIOs. It adds a set/clear register pair for atomic bit updates and a per-bit hardware blink engine, so software does not need timer interrupts to flash LEDs. It sits on the CPU data master's slave fabric alongside the other PIO peripherals.

## Interface
- WIDTH, 8: number of output bits; legal range 1..32.
- RESET_VALUE, 0: reset value of the DATA register, WIDTH bits.
- DEFAULT_PERIOD, 25000000: reset value of the PERIOD register, in clk cycles.

- clk  input  1  system clock; the block has one clock.
- reset_n  input  1  asynchronous, active-low reset.
- address  input  3  word offset of the slave register.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- readdata  output  32  registered read data.
- out_port  output  WIDTH  registered LED drive.

## Operation
- A write occurs in a cycle when chipselect=1 and write_n=0. There is at most one write per cycle, so set and clear never collide.
- Register map (word offsets):
  - 0 DATA, RW: output data. Only bits [WIDTH-1:0] are stored; upper bits read 0.
  - 1 BLINK_EN, RW: per-bit blink mask, WIDTH bits.
  - 2 PERIOD, RW: 32-bit half-period in cycles. A write clears the blink counter and the phase.
  - 3 STATUS, RO: bit0 = current phase; other bits 0. Writes are ignored.
  - 4 OUTSET, WO: DATA <= DATA | writedata[WIDTH-1:0]. Reads return 0.
  - 5 OUTCLEAR, WO: DATA <= DATA & ~writedata[WIDTH-1:0]. Reads return 0.
  - 6, 7: reads return 0; writes are ignored.
- Blink engine: a 32-bit counter cnt and a phase bit.
  - When PERIOD≠0: each cycle, if cnt == PERIOD-1, then cnt <= 0 and phase toggles; otherwise cnt increments.
  - When PERIOD=0: cnt and phase hold, and blinking freezes in its current phase.
  - A PERIOD write forces cnt=0 and phase=0 in the same edge. That write takes priority over the wrap.
  - A BLINK_EN or DATA write does not disturb cnt or phase.
- Output function: out_port <= DATA ^ (BLINK_EN & {WIDTH{phase}}), registered every cycle.
  - A blinking bit alternates between its DATA value and the complement of its DATA value.
- Reads: every cycle, readdata <= the mux of address, independent of chipselect and with no read strobe. This gives the same read behaviour as the input PIOs.

## Timing
- Reset (asynchronous assert, synchronous release):
  - DATA=RESET_VALUE, BLINK_EN=0, PERIOD=DEFAULT_PERIOD, cnt=0, phase=0.
  - out_port=RESET_VALUE[WIDTH-1:0], readdata=0.
- Write at edge N updates the register at N. out_port reflects the change at edge N+1.
- Read latency is 1: address presented before edge N gives valid readdata after N. A read in the same cycle as a write to that address returns the old value.
- The phase toggles at the edge where cnt == PERIOD-1.
  - With PERIOD=P, phase is stable for P cycles.
  - With P=1, phase toggles every cycle.
  - Blinking out_port edges lag phase edges by 1 cycle.
- PERIOD write while cnt > new PERIOD: the forced clear avoids a 2^32 wrap.
- Reset mid-blink returns everything to reset values immediately. No pending write survives.

## Structure
- Shared package cpu_pio_led_pkg:
  - register offset constants ADDR_DATA=0, ADDR_BLINK_EN=1, ADDR_PERIOD=2, ADDR_STATUS=3, ADDR_OUTSET=4, ADDR_OUTCLEAR=5;
  - STATUS_PHASE_BIT=0.
- One sub-module, cpu_pio_led_blink_timer. It holds cnt and phase, with inputs period[31:0] and period_wr, and output phase.
- The top level holds the register file, the read mux and the out_port register.

## Test plan
- Reset with RESET_VALUE=8'hA5 -> out_port=8'hA5, readdata=0. Read PERIOD -> DEFAULT_PERIOD after 1 cycle.
- Write DATA=8'h0F, then OUTSET=8'h30, then OUTCLEAR=8'h01 -> out_port=8'h3E, read DATA=0x0000003E. Read offset 4 -> 0.
- PERIOD=4, BLINK_EN=8'h81, DATA=8'h00 -> out_port alternates 8'h00/8'h81 every 4 cycles. STATUS bit0 tracks phase one cycle ahead of out_port.
- Mid-blink with phase=1 and cnt=2: write PERIOD=3 -> phase=0 and cnt=0 at that edge; next toggle 3 cycles later. Then write PERIOD=0 -> out_port frozen for 100 cycles.
- PERIOD=1, BLINK_EN=8'hFF, DATA=8'h55 -> out_port alternates 8'h55/8'hAA every cycle.
- Assert reset_n low asynchronously mid-blink -> out_port returns to RESET_VALUE and readdata=0 without a clock edge. After release, blinking stays disabled (BLINK_EN=0).
